// File: rtl/serial_sub_pkg.sv
// serial_sub shared types and constants.
// Imported by the bit-serial subtractor top.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/half_sub.sv
// Half subtractor: diff = x - y, borrow out when x < y.
// Two of these plus an OR make the per-bit full subtractor.
module half_sub (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y;
  assign bout = ~x & y;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, registered borrow.
// start/busy/done handshake; d and bo held until the next launch.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;

  logic diff1, bout1;
  logic diff, bout2;
  logic bnext;

  half_sub u_hs0 (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .diff (diff1),
    .bout (bout1)
  );

  half_sub u_hs1 (
    .x    (diff1),
    .y    (br_q),
    .diff (diff),
    .bout (bout2)
  );

  assign bnext = bout1 | bout2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sh_d    = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        sh_d = {diff, sh_q[WIDTH-1:1]};
        br_d = bnext;
        if (cnt_q == LAST) begin
          // Result registers load on the final bit so DONE sees them.
          d_d     = {diff, sh_q[WIDTH-1:1]};
          bo_d    = bnext;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bo   = bo_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub with a cycle-level reference model.
// Model predicts busy/done/d/bo from plain arithmetic on captured operands.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, bo;
  logic [W-1:0] d;

  int n_cmp = 0;
  int n_err = 0;
  bit en = 1'b0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo)
  );

  always #5 clk = ~clk;

  int           m_rem;
  logic         m_done, m_bo;
  logic [W-1:0] m_a, m_b, m_d;

  // Model: an accepted start opens a W-edge window; its last edge yields a-b.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_d    <= '0;
      m_bo   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0 && start) begin
        m_a   <= a;
        m_b   <= b;
        m_rem <= W;
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_d    <= W'(m_a - m_b);
          m_bo   <= (m_a < m_b);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_rem != 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("d", {24'd0, d}, {24'd0, m_d});
      chk("bo", {31'd0, bo}, {31'd0, m_bo});
      chk("excl", {31'd0, busy & done}, 32'd0);
    end
  end

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] ed, input logic eb,
                        input bit timing);
    int lat;
    int bc;
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    if (timing) begin
      chk("latency", lat, W);
      chk("busy_len", bc, W);
    end
    chk("op_d", {24'd0, d}, {24'd0, ed});
    chk("op_bo", {31'd0, bo}, {31'd0, eb});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_d", {24'd0, d}, 32'd0);

    run_op(8'd200, 8'd55, 8'd145, 1'b0, 1'b1);
    run_op(8'h05, 8'h0A, 8'hFB, 1'b1, 1'b1);

    // Mid-clock reset must clear outputs without waiting for an edge.
    start = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    start = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_d", {24'd0, d}, 32'd0);
    chk("arst_bo", {31'd0, bo}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

    // Held start: operands change mid-run, then back-to-back restart.
    @(negedge clk);
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    wait_done();
    chk("b2b1_d", {24'd0, d}, 32'h22);
    chk("b2b1_bo", {31'd0, bo}, 32'd0);
    @(negedge clk);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done();
    chk("b2b2_d", {24'd0, d}, 32'h0F);
    chk("b2b2_bo", {31'd0, bo}, 32'd0);

    // Abort in the middle of a run.
    @(negedge clk);
    a = 8'h55;
    b = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_d", {24'd0, d}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("abort_nodone", {31'd0, done}, 32'd0);
    end
    run_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
